onewire_serial_xcvr: RTL and testbench

Parametrised half-duplex single-wire serial transceiver, successor to the fixed 8-bit fast serial bus. It moves one frame at a time over a shared tristate line: a start bit, DATA_W data bits LSB first, optional parity, then stop bits. The bit period is runtime-programmable, and receive uses mid-bit sampling with parity and framing error reporting. It sits between the task/core logic (valid/ready on the transmit side, one-cycle strobe on the receive side) and the shared board-level line.

---
 rtl/onewire_serial_xcvr_if.sv | 24 ++
 rtl/onewire_serial_xcvr.sv | 149 ++++++++++++++
 tb/tb_onewire_serial_xcvr.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/onewire_serial_xcvr_if.sv
// onewire_serial_xcvr_if: core-side transmit/receive handshake bundle for the single-wire transceiver
interface onewire_serial_xcvr_if #(
  parameter int DATA_W = 8,
  parameter int CYC_W  = 16
);
  logic [CYC_W-1:0]  cycle;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_done;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err_par;
  logic              rx_err_frm;
  logic              busy;
  modport master (
    output cycle, tx_data, tx_valid,
    input  tx_ready, tx_done, rx_data, rx_valid, rx_err_par, rx_err_frm, busy
  );
  modport slave (
    input  cycle, tx_data, tx_valid,
    output tx_ready, tx_done, rx_data, rx_valid, rx_err_par, rx_err_frm, busy
  );
endinterface

// File: rtl/onewire_serial_xcvr.sv
// onewire_serial_xcvr: half-duplex single-wire framed transceiver (clk, rst_n, shared RxTx line, core handshake via bus)
module onewire_serial_xcvr #(
  parameter int DATA_W     = 8,
  parameter int CYC_W      = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int TURN_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout  wire                  RxTx,
  onewire_serial_xcvr_if.slave bus
);
  localparam int N     = 1 + DATA_W + PARITY_EN + STOP_BITS;
  localparam int M     = N - 1;
  localparam int IDX_W = $clog2((N > TURN_BITS ? N : TURN_BITS) + 1);
  typedef enum logic [2:0] {IDLE, TX_BIT, RX_START, RX_BIT, TURN} state_e;
  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d, cyc_q, cyc_d, cyc_in;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N-1:0]      tx_sh_q, tx_sh_d, tx_frame;
  logic [M-1:0]      rx_sh_q, rx_sh_d, rx_shift;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              err_par_q, err_par_d, err_frm_q, err_frm_d;
  logic              tx_done_q, tx_done_d, rx_valid_q, rx_valid_d;
  logic              meta_q, line_s_q, line_p_q;
  logic              rise, tx_ready, period_end, rx_par_bad, rx_frm_bad;
  state_e            after_frame;
  assign RxTx = (state_q == TX_BIT) ? tx_sh_q[0] : 1'bz;
  assign rise        = line_s_q & ~line_p_q;
  assign tx_ready    = (state_q == IDLE) && !line_s_q;
  assign period_end  = cnt_q == cyc_q - CYC_W'(1);
  assign cyc_in      = (bus.cycle < CYC_W'(4)) ? CYC_W'(4) : bus.cycle;
  assign rx_shift    = {line_s_q, rx_sh_q[M-1:1]};
  assign rx_par_bad  = (PARITY_EN != 0) && (rx_shift[DATA_W] ^ (^rx_shift[DATA_W-1:0]) ^ 1'(PARITY_ODD));
  assign rx_frm_bad  = |rx_shift[M-1 -: STOP_BITS];
  assign after_frame = (TURN_BITS == 0) ? IDLE : TURN;
  always_comb begin
    tx_frame             = '0;
    tx_frame[0]          = 1'b1;
    tx_frame[DATA_W:1]   = bus.tx_data;
    tx_frame[DATA_W+1]   = (PARITY_EN != 0) ? (^bus.tx_data) ^ 1'(PARITY_ODD) : 1'b0;
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CYC_W'(1);
    idx_d      = idx_q;
    cyc_d      = cyc_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    err_par_d  = err_par_q;
    err_frm_d  = err_frm_q;
    tx_done_d  = 1'b0;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rise) begin
          state_d = RX_START;
          cyc_d   = cyc_in;
        end else if (bus.tx_valid && tx_ready) begin
          state_d = TX_BIT;
          cyc_d   = cyc_in;
          tx_sh_d = tx_frame;
        end
      end
      TX_BIT: if (period_end) begin
        cnt_d   = '0;
        idx_d   = idx_q + IDX_W'(1);
        tx_sh_d = tx_sh_q >> 1;
        if (idx_q == IDX_W'(N-1)) begin
          state_d   = after_frame;
          idx_d     = '0;
          tx_done_d = 1'b1;
        end
      end
      RX_START: if (cnt_q == (cyc_q >> 1)) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = line_s_q ? RX_BIT : IDLE;
      end
      RX_BIT: if (period_end) begin
        cnt_d   = '0;
        idx_d   = idx_q + IDX_W'(1);
        rx_sh_d = rx_shift;
        if (idx_q == IDX_W'(M-1)) begin
          state_d    = after_frame;
          idx_d      = '0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift[DATA_W-1:0];
          err_par_d  = rx_par_bad;
          err_frm_d  = rx_frm_bad;
        end
      end
      TURN: if (period_end) begin
        cnt_d = '0;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(TURN_BITS-1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      cyc_q      <= CYC_W'(4);
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      meta_q     <= 1'b0;
      line_s_q   <= 1'b0;
      line_p_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      cyc_q      <= cyc_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
      tx_done_q  <= tx_done_d;
      rx_valid_q <= rx_valid_d;
      meta_q     <= RxTx;
      line_s_q   <= meta_q;
      line_p_q   <= line_s_q;
    end
  end
  assign bus.tx_ready   = tx_ready;
  assign bus.tx_done    = tx_done_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_err_par = err_par_q;
  assign bus.rx_err_frm = err_frm_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_onewire_serial_xcvr.sv
// tb_onewire_serial_xcvr: directed checks of framing, timing, RX errors, glitch rejection, reset and loopback
module tb_onewire_serial_xcvr;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic drv_en = 1'b0;
  logic drv_val = 1'b0;
  wire  line_a, line_b;
  int   checks = 0, errors = 0;
  int   txd_a = 0, rxv_a = 0, rxv_c = 0;
  logic [7:0] cap_data = '0;
  logic cap_par = 1'b0, cap_frm = 1'b0;
  always #5 clk = ~clk;
  assign line_a = drv_en ? drv_val : 1'bz;
  pulldown (line_a);
  pulldown (line_b);
  onewire_serial_xcvr_if #(.DATA_W(8),  .CYC_W(16)) bus_a();
  onewire_serial_xcvr_if #(.DATA_W(12), .CYC_W(16)) bus_b();
  onewire_serial_xcvr_if #(.DATA_W(12), .CYC_W(16)) bus_c();
  onewire_serial_xcvr #(.DATA_W(8), .CYC_W(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .TURN_BITS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .RxTx(line_a), .bus(bus_a));
  onewire_serial_xcvr #(.DATA_W(12), .CYC_W(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .TURN_BITS(1))
    dut_b (.clk(clk), .rst_n(rst_n), .RxTx(line_b), .bus(bus_b));
  onewire_serial_xcvr #(.DATA_W(12), .CYC_W(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .TURN_BITS(1))
    dut_c (.clk(clk), .rst_n(rst_n), .RxTx(line_b), .bus(bus_c));
  always @(negedge clk) begin
    if (bus_a.tx_done) txd_a++;
    if (bus_a.rx_valid) begin
      rxv_a++;
      cap_data = bus_a.rx_data;
      cap_par  = bus_a.rx_err_par;
      cap_frm  = bus_a.rx_err_frm;
    end
    if (bus_c.rx_valid) rxv_c++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_tx(input logic [7:0] d, input logic [10:0] pat, input int cin, input int ce);
    @(negedge clk);
    chk("tx_ready_before", bus_a.tx_ready, 1);
    bus_a.cycle = 16'(cin);
    bus_a.tx_data = d;
    bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    bus_a.cycle = 16'(2 * cin);
    for (int i = 1; i <= 1 + 12 * ce; i++) begin
      if (i > 1) @(negedge clk);
      if (i <= 11 * ce && (i - 1) % ce == ce / 2) chk("tx_bit", line_a, pat[(i - 1) / ce]);
      if (i == 11 * ce) chk("tx_done_early", bus_a.tx_done, 0);
      if (i == 1 + 11 * ce) begin
        chk("tx_done", bus_a.tx_done, 1);
        chk("tx_released", line_a, 0);
      end
      if (i == 2 + 11 * ce) chk("tx_done_pulse", bus_a.tx_done, 0);
      if (i == 12 * ce) chk("turn_not_ready", bus_a.tx_ready, 0);
      if (i == 1 + 12 * ce) chk("turn_ready", bus_a.tx_ready, 1);
    end
  endtask
  initial begin
    int base, w;
    logic [10:0] bad;
    bus_a.cycle = 16'd10; bus_a.tx_data = '0; bus_a.tx_valid = 1'b0;
    bus_b.cycle = 16'd7;  bus_b.tx_data = '0; bus_b.tx_valid = 1'b0;
    bus_c.cycle = 16'd7;  bus_c.tx_data = '0; bus_c.tx_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_tx_done", bus_a.tx_done, 0);
    chk("rst_rx_valid", bus_a.rx_valid, 0);
    chk("rst_rx_data", bus_a.rx_data, 0);
    chk("rst_err_par", bus_a.rx_err_par, 0);
    chk("rst_err_frm", bus_a.rx_err_frm, 0);
    chk("rst_line", line_a, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_ready", bus_a.tx_ready, 1);
    run_tx(8'hA5, 11'b00101001011, 10, 10);
    run_tx(8'h5A, 11'b00010110101, 2, 4);
    bus_a.cycle = 16'd16;
    base = rxv_a;
    drv_val = 1'b1;
    drv_en = 1'b1;
    repeat (3) @(negedge clk);
    drv_en = 1'b0;
    drv_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_rx_start", bus_a.busy, 1);
    repeat (30) @(negedge clk);
    chk("glitch_no_rx", rxv_a, base);
    chk("glitch_idle", bus_a.busy, 0);
    chk("glitch_ready", bus_a.tx_ready, 1);
    bus_a.cycle = 16'd10;
    base = rxv_a;
    bad = {1'b1, 1'b1, 8'h3C, 1'b1};
    drv_en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      drv_val = bad[k];
      repeat (10) @(negedge clk);
    end
    drv_en = 1'b0;
    drv_val = 1'b0;
    repeat (20) @(negedge clk);
    chk("bad_rx_count", rxv_a, base + 1);
    chk("bad_rx_data", cap_data, 8'h3C);
    chk("bad_err_par", cap_par, 1);
    chk("bad_err_frm", cap_frm, 1);
    chk("bad_data_held", bus_a.rx_data, 8'h3C);
    chk("bad_ready", bus_a.tx_ready, 1);
    base = txd_a;
    bus_a.tx_data = 8'hFF;
    bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    repeat (34) @(negedge clk);
    chk("mid_bit3_high", line_a, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_release", line_a, 0);
    chk("mid_rst_busy", bus_a.busy, 0);
    chk("mid_rst_done", bus_a.tx_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    chk("mid_rst_no_done", txd_a, base);
    chk("mid_rst_ready", bus_a.tx_ready, 1);
    run_tx(8'h01, 11'b01000000011, 10, 10);
    base = rxv_c;
    @(negedge clk);
    chk("lb_ready", bus_b.tx_ready, 1);
    bus_b.tx_data = 12'h3C1;
    bus_b.tx_valid = 1'b1;
    @(negedge clk);
    bus_b.tx_valid = 1'b0;
    w = 0;
    while (rxv_c == base && w < 400) begin
      @(negedge clk);
      w++;
    end
    #1;
    chk("lb_rx_seen", rxv_c, base + 1);
    chk("lb_rx_data", bus_c.rx_data, 12'h3C1);
    chk("lb_err_par", bus_c.rx_err_par, 0);
    chk("lb_err_frm", bus_c.rx_err_frm, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
